// File: rtl/pipe_pkg.sv
// Shared definitions for the flow-controlled arithmetic pipeline:
// op encodings and the default operand width.
package pipe_pkg;

    localparam int DEFAULT_N = 10;

    typedef enum logic [1:0] {
        OP_MAC  = 2'b00,
        OP_SUM  = 2'b01,
        OP_PROD = 2'b10,
        OP_SAT  = 2'b11
    } op_e;

endpackage

// File: rtl/pipe_stage_ctl.sv
// Valid bit and advance term for one pipeline stage. The stage may load
// whenever it is empty or the stage downstream is moving.
module pipe_stage_ctl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic v_prev,
    input  logic adv_next,
    output logic v,
    output logic adv
);

    logic v_q;
    logic v_d;

    always_comb begin
        adv = ~v_q | adv_next;
        v_d = v_q;
        // flush wins over any load arriving in the same cycle
        if (flush) begin
            v_d = 1'b0;
        end else if (adv) begin
            v_d = v_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign v = v_q;

endmodule

// File: rtl/pipe_arith_hs.sv
// Three-stage valid/ready pipeline computing a selectable function of a, b, c, d.
// Stage 1: x1=a+b, x2=c-d. Stage 2: x3=x1+x2. Stage 3: result selected by op.
module pipe_arith_hs
    import pipe_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int OUT_W = 2 * N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     c,
    input  logic [N-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] f,
    output logic [1:0]       occ
);

    generate
        if (OUT_W < 2 * N) begin : g_bad_out_w
            $error("pipe_arith_hs: OUT_W must be at least 2*N");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, ready is combinational from out_ready.
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    pipe_stage_ctl u_ctl1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .v_prev   (in_valid),
        .adv_next (adv2),
        .v        (v1),
        .adv      (adv1)
    );

    pipe_stage_ctl u_ctl2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .v_prev   (v1),
        .adv_next (adv3),
        .v        (v2),
        .adv      (adv2)
    );

    pipe_stage_ctl u_ctl3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .v_prev   (v2),
        .adv_next (out_ready),
        .v        (v3),
        .adv      (adv3)
    );

    assign in_ready  = adv1;
    assign out_valid = v3;
    assign occ       = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

    logic [N-1:0]     s1_x1_q, s1_x1_d;
    logic [N-1:0]     s1_x2_q, s1_x2_d;
    logic [N-1:0]     s1_d_q,  s1_d_d;
    op_e              s1_op_q, s1_op_d;
    logic [N-1:0]     s2_x1_q, s2_x1_d;
    logic [N-1:0]     s2_x2_q, s2_x2_d;
    logic [N-1:0]     s2_x3_q, s2_x3_d;
    logic [N-1:0]     s2_d_q,  s2_d_d;
    op_e              s2_op_q, s2_op_d;
    logic [OUT_W-1:0] f_q, f_d;

    logic [2*N-1:0]   mac_prod;
    logic [2*N-1:0]   x12_prod;
    logic [OUT_W-1:0] res;

    assign mac_prod = {{N{1'b0}}, s2_x3_q} * {{N{1'b0}}, s2_d_q};
    assign x12_prod = {{N{1'b0}}, s2_x1_q} * {{N{1'b0}}, s2_x2_q};

    always_comb begin
        res = '0;
        case (s2_op_q)
            OP_MAC:  res[2*N-1:0] = mac_prod;
            OP_SUM:  res[N-1:0]   = s2_x3_q;
            OP_PROD: res[2*N-1:0] = x12_prod;
            OP_SAT:  res[N-1:0]   = (|mac_prod[2*N-1:N]) ? {N{1'b1}} : mac_prod[N-1:0];
            default: res = '0;
        endcase
    end

    always_comb begin
        s1_x1_d = s1_x1_q;
        s1_x2_d = s1_x2_q;
        s1_d_d  = s1_d_q;
        s1_op_d = s1_op_q;
        s2_x1_d = s2_x1_q;
        s2_x2_d = s2_x2_q;
        s2_x3_d = s2_x3_q;
        s2_d_d  = s2_d_q;
        s2_op_d = s2_op_q;
        f_d     = f_q;
        if (adv1) begin
            s1_x1_d = a + b;
            s1_x2_d = c - d;
            s1_d_d  = d;
            s1_op_d = op_e'(op);
        end
        if (adv2) begin
            s2_x1_d = s1_x1_q;
            s2_x2_d = s1_x2_q;
            s2_x3_d = s1_x1_q + s1_x2_q;
            s2_d_d  = s1_d_q;
            s2_op_d = s1_op_q;
        end
        if (adv3) begin
            f_d = res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x1_q <= '0;
            s1_x2_q <= '0;
            s1_d_q  <= '0;
            s1_op_q <= OP_MAC;
            s2_x1_q <= '0;
            s2_x2_q <= '0;
            s2_x3_q <= '0;
            s2_d_q  <= '0;
            s2_op_q <= OP_MAC;
            f_q     <= '0;
        end else begin
            s1_x1_q <= s1_x1_d;
            s1_x2_q <= s1_x2_d;
            s1_d_q  <= s1_d_d;
            s1_op_q <= s1_op_d;
            s2_x1_q <= s2_x1_d;
            s2_x2_q <= s2_x2_d;
            s2_x3_q <= s2_x3_d;
            s2_d_q  <= s2_d_d;
            s2_op_q <= s2_op_d;
            f_q     <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Bench for pipe_arith_hs: vector table, handshake corner sequences and a
// scoreboard queue compared on every output transfer.
module tb_pipe_arith_hs;

    localparam int N     = 10;
    localparam int OUT_W = 2 * N;
    localparam int M     = 1 << N;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [N-1:0]     a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] f;
    logic [1:0]       occ;

    pipe_arith_hs #(.N(N), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .occ       (occ)
    );

    typedef struct {
        logic [1:0]       op;
        int               a, b, c, d;
        logic [OUT_W-1:0] f;
    } vec_t;

    vec_t             tbl[13];
    logic [OUT_W-1:0] exp_q[$];
    int               out_cyc[$];
    int               n_cmp;
    int               n_bad;
    int               cyc;
    bit               rnd_rdy;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [1:0] o, input int aa, input int bb,
                                               input int cc, input int dd);
        longint x1, x2, x3, p;
        x1 = (aa + bb) % M;
        x2 = ((cc - dd) % M + M) % M;
        x3 = (x1 + x2) % M;
        case (o)
            2'b00:   p = x3 * dd;
            2'b01:   p = x3;
            2'b10:   p = x1 * x2;
            default: p = (x3 * dd > M - 1) ? M - 1 : x3 * dd;
        endcase
        return OUT_W'(p);
    endfunction

    // Drives one operand set from posedge+1 until accepted; returns at posedge+1.
    task automatic drive(input logic [1:0] o, input int aa, input int bb, input int cc,
                         input int dd, input logic [OUT_W-1:0] e);
        int t;
        bit done;
        t    = 0;
        done = 0;
        op = o; a = N'(aa); b = N'(bb); c = N'(cc); d = N'(dd);
        in_valid = 1'b1;
        while (!done && t < 200) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!done) check("drive_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic lat3();
        @(negedge clk); check("lat_c1_out_valid", out_valid, 0);
        @(negedge clk); check("lat_c2_out_valid", out_valid, 0);
        @(negedge clk); check("lat_c3_out_valid", out_valid, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d expected none", f);
            end else begin
                check("f", f, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- test ----------------
    initial begin
        logic [OUT_W-1:0] bp_exp[6];
        int               bp_a[6];
        int               idx;
        int               ro, ra, rb, rc, rd;

        tbl[0]  = '{2'b00,    5,   3,   20,    4, 20'd96};
        tbl[1]  = '{2'b01, 1000, 100,    0,    1, 20'd75};
        tbl[2]  = '{2'b00, 1000, 100,    0,    1, 20'd75};
        tbl[3]  = '{2'b00,    5,   3,   20,    4, 20'd96};
        tbl[4]  = '{2'b01,    5,   3,   20,    4, 20'd24};
        tbl[5]  = '{2'b10,    5,   3,   20,    4, 20'd128};
        tbl[6]  = '{2'b11,    5,   3,   20,    4, 20'd96};
        tbl[7]  = '{2'b11,    5,   3,   20,  100, 20'd1023};
        tbl[8]  = '{2'b10, 1023,   0, 1023,    0, 20'd1046529};
        tbl[9]  = '{2'b00,  500,   0, 1023, 1000, 20'd523000};
        tbl[10] = '{2'b11, 1022,   0,    2,    1, 20'd1023};
        tbl[11] = '{2'b11,  510,   0,    4,    2, 20'd1023};
        tbl[12] = '{2'b01,  510,   0,    4,    2, 20'd512};

        n_cmp = 0; n_bad = 0; cyc = 0; rnd_rdy = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; c = '0; d = '0;

        // reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occ, 0);
        check("rst_f", f, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // basic transaction with exact latency
        drive(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, tbl[0].f);
        lat3();
        drain();

        // table back-to-back: one result per cycle
        out_cyc.delete();
        for (int i = 1; i < 13; i++) drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].f);
        drain();
        check("tbl_out_count", out_cyc.size(), 12);
        if (out_cyc.size() == 12) check("tbl_out_span", out_cyc[11] - out_cyc[0], 11);

        // backpressure: 6 items, consumer stalled
        for (int i = 0; i < 6; i++) begin
            bp_a[i]   = 10 * i + 1;
            bp_exp[i] = model(2'b00, bp_a[i], 2, 30, 3);
        end
        out_ready = 1'b0;
        idx = 0;
        op = 2'b00; a = N'(bp_a[0]); b = 10'd2; c = 10'd30; d = 10'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready && idx < 6) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 6) a = N'(bp_a[idx]);
        end
        check("bp_accepts", idx, 3);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_occ", occ, 3);
        check("bp_out_valid", out_valid, 1);
        check("bp_f_hold", f, bp_exp[0]);
        @(posedge clk); #1;
        out_cyc.delete();
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) drive(2'b00, bp_a[i], 2, 30, 3, bp_exp[i]);
        drain();
        check("bp_out_count", out_cyc.size(), 6);
        if (out_cyc.size() == 6) check("bp_out_span", out_cyc[5] - out_cyc[0], 5);

        // flush with a simultaneous valid input
        for (int i = 0; i < 3; i++) drive(2'b01, 100 + i, 0, 0, 0, model(2'b01, 100 + i, 0, 0, 0));
        op = 2'b01; a = 10'd200; b = '0; c = '0; d = '0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_occ", occ, 0);
        check("flush_out_valid", out_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        drive(2'b00, 7, 1, 9, 2, model(2'b00, 7, 1, 9, 2));
        lat3();
        drain();

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) drive(2'b10, 30 + i, 1, 50, 5, model(2'b10, 30 + i, 1, 50, 5));
        #2 rst_n = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_f", f, 0);
        check("areset_occ", occ, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(2'b00, 5, 3, 20, 4, 20'd96);
        lat3();
        drain();

        // random operands with random consumer stalls
        rnd_rdy = 1;
        for (int i = 0; i < 30; i++) begin
            ro = $urandom_range(0, 3);
            ra = $urandom_range(0, M - 1);
            rb = $urandom_range(0, M - 1);
            rc = $urandom_range(0, M - 1);
            rd = $urandom_range(0, M - 1);
            drive(2'(ro), ra, rb, rc, rd, model(2'(ro), ra, rb, rc, rd));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        rnd_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_arith_hs.md
Name: pipe_arith_hs

Overview:
Three-stage arithmetic pipeline that computes a selectable function of four N-bit operands. It is the parametrised, flow-controlled successor to the team's fixed datapath, which computes F = ((A+B)+(C-D))*D.
- Adds valid/ready handshakes at both ends, so stalls propagate backwards without data loss.
- Adds a per-transaction op mode, a full-width product, a synchronous flush and an occupancy count.
- Sits between an operand producer and a result consumer, both using valid/ready.

Parameters:
N, 10, operand width; intermediate results x1, x2, x3 are N bits, modulo 2^N.
OUT_W, 2*N, result width; must be at least 2*N (elaboration check).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; clears all stage valids in the cycle it is sampled high
in_valid  input  1  operand set presented
in_ready  output  1  pipeline accepts the operand set this cycle
op  input  2  mode, captured with the operands
a, b, c, d  input  N each  operands
out_valid  output  1  result presented
out_ready  input  1  consumer accepts the result
f  output  OUT_W  result
occ  output  2  number of occupied stages (0..3)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Stage valids v1, v2, v3 = 0; out_valid = 0; f = 0; occ = 0; in_ready = 1 one cycle after release.
  - Data registers reset to 0.
  - Reset mid-transfer drops all in-flight items.
- Stage 1 (on accept):
  - x1 = (a+b) mod 2^N; x2 = (c-d) mod 2^N.
  - Registers x1, x2, d, op.
- Stage 2:
  - x3 = (x1+x2) mod 2^N.
  - Carries x1, x2, d, op forward.
- Stage 3, result by op:
  - 00: f = x3*d, full 2N-bit unsigned product, zero-extended to OUT_W.
  - 01: f = x3, zero-extended.
  - 10: f = x1*x2, full unsigned product.
  - 11: f = min(x3*d, 2^N-1), saturated to N bits, zero-extended.
- Flow control:
  - adv3 = ~v3 | out_ready; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2.
  - in_ready = adv1 (combinational from out_ready, no register in the ready path).
  - Stage k loads from stage k-1 when adv_k. Its valid becomes v_{k-1}, or in_valid&in_ready for stage 1.
- Latency: exactly 3 cycles from accept to out_valid with no stalls. Throughput is 1 result per cycle.
- Stall:
  - With out_ready=0 and v3=1, f and out_valid hold stable.
  - Upstream bubbles collapse until all 3 stages are full; then in_ready=0.
  - Never drop or duplicate an item.
- Simultaneous events:
  - Accept into stage 1 and output transfer in the same cycle is legal; occ is unchanged.
  - flush has priority over an accept in the same cycle: v1, v2, v3 are cleared and the incoming item is dropped, even though in_ready was high.
  - out_valid drops the next cycle after flush.
- occ = v1+v2+v3 (registered valids).
- Data registers of invalid stages may hold stale values. f is only meaningful while out_valid=1.

Decomposition:
- Shared package pipe_pkg:
  - op encodings OP_MAC=2'b00, OP_SUM=2'b01, OP_PROD=2'b10, OP_SAT=2'b11.
  - Default width constant.
- One natural sub-module, pipe_stage_ctl: valid/advance logic for a single stage (inputs v_prev, adv_next, flush; outputs v, adv). Instantiate it three times.
- The arithmetic stays in the top level.

Test Plan:
- Basic: N=10, op=00, a=5, b=3, c=20, d=4, out_ready=1 -> out_valid exactly 3 cycles after accept, f=96; x1=8, x2=16, x3=24.
- Wrap: op=01, a=1000, b=100, c=0, d=1 -> x1=76, x2=1023, f=75. Then op=00 with the same operands -> f=75.
- Modes back-to-back (a=5, b=3, c=20, d=4) with ops 00, 01, 10, 11 in consecutive cycles -> f = 96, 24, 128, 96 on 4 consecutive cycles. Then op=11 with a=5, b=3, c=20, d=100 -> x2=944 and x3=952, so f=1023 (saturated, 95200 > 1023).
- Backpressure:
  - Stream 6 items while out_ready=0 -> in_ready drops after 3 accepts; occ=3; f holds item 0.
  - Release out_ready -> items emerge in order, none lost, one per cycle.
- Flush: 3 items in flight, flush=1 together with in_valid=1 -> next cycle occ=0, out_valid=0, no flushed item ever appears. The next accepted item appears 3 cycles after its accept.
- Async reset: assert rst_n low mid-stream between clock edges -> out_valid, f and occ go to 0 immediately. After release, first accept yields a correct result 3 cycles later.
